// File: rtl/instruction_fetch.sv
// Fetches one 16-bit instruction as two byte reads (high byte at PC, low byte at PC+1).
// Latency 3 cycles from start to strobe with immediate acks; waits indefinitely for mem_ack_in.
module instruction_fetch #(
    parameter logic [15:0] PC_RESET = 16'h0000
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic        fetch_start_in,
    input  logic        jump_en_in,
    input  logic [15:0] jump_addr_in,
    input  logic        abort_in,
    output logic        mem_req_out,
    output logic [15:0] mem_addr_out,
    input  logic        mem_ack_in,
    input  logic [7:0]  mem_data_in,
    output logic        ir_write_en_out,
    output logic [15:0] ir_data_out,
    output logic [15:0] pc_out,
    output logic        busy_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ_HI = 2'd1,
        REQ_LO = 2'd2,
        WRITE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [7:0]  hi_q, hi_d;
    logic [15:0] ir_data_q, ir_data_d;

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q   <= IDLE;
            pc_q      <= PC_RESET;
            hi_q      <= 8'h00;
            ir_data_q <= 16'h0000;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            hi_q      <= hi_d;
            ir_data_q <= ir_data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        hi_d      = hi_q;
        ir_data_d = ir_data_q;
        case (state_q)
            IDLE: begin
                // A jump and a start in the same cycle fetch from the jump target.
                if (jump_en_in) begin
                    pc_d = jump_addr_in;
                end
                if (fetch_start_in) begin
                    state_d = REQ_HI;
                end
            end
            REQ_HI: begin
                if (abort_in) begin
                    state_d = IDLE;
                    hi_d    = 8'h00;
                end else if (mem_ack_in) begin
                    hi_d    = mem_data_in;
                    state_d = REQ_LO;
                end
            end
            REQ_LO: begin
                if (abort_in) begin
                    state_d = IDLE;
                    hi_d    = 8'h00;
                end else if (mem_ack_in) begin
                    ir_data_d = {hi_q, mem_data_in};
                    state_d   = WRITE;
                end
            end
            WRITE: begin
                // The strobe is already committed; abort only cancels the PC advance.
                state_d = IDLE;
                if (!abort_in) begin
                    pc_d = pc_q + 16'd2;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_req_out     = (state_q == REQ_HI) || (state_q == REQ_LO);
    assign mem_addr_out    = (state_q == REQ_LO) ? (pc_q + 16'd1) : pc_q;
    assign ir_write_en_out = (state_q == WRITE);
    assign ir_data_out     = ir_data_q;
    assign pc_out          = pc_q;
    assign busy_out        = (state_q != IDLE);

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: each task drives one scenario and checks outputs
// one time unit after the rising edge, against hand-computed values.
module tb_instruction_fetch;

    logic        clk_in = 1'b0;
    logic        reset_in = 1'b0;
    logic        fetch_start_in = 1'b0;
    logic        jump_en_in = 1'b0;
    logic [15:0] jump_addr_in = 16'h0000;
    logic        abort_in = 1'b0;
    logic        mem_req_out;
    logic [15:0] mem_addr_out;
    logic        mem_ack_in = 1'b0;
    logic [7:0]  mem_data_in = 8'h00;
    logic        ir_write_en_out;
    logic [15:0] ir_data_out;
    logic [15:0] pc_out;
    logic        busy_out;

    int checks = 0;
    int errors = 0;

    instruction_fetch #(.PC_RESET(16'h0000)) dut (
        .clk_in          (clk_in),
        .reset_in        (reset_in),
        .fetch_start_in  (fetch_start_in),
        .jump_en_in      (jump_en_in),
        .jump_addr_in    (jump_addr_in),
        .abort_in        (abort_in),
        .mem_req_out     (mem_req_out),
        .mem_addr_out    (mem_addr_out),
        .mem_ack_in      (mem_ack_in),
        .mem_data_in     (mem_data_in),
        .ir_write_en_out (ir_write_en_out),
        .ir_data_out     (ir_data_out),
        .pc_out          (pc_out),
        .busy_out        (busy_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset();
        reset_in = 1'b1;
        tick();
        tick();
        checks++;
        if ({mem_req_out, ir_write_en_out, busy_out} !== 3'b000) begin
            errors++; $display("FAIL reset_ctrl got %b want 000", {mem_req_out, ir_write_en_out, busy_out});
        end
        checks++;
        if (ir_data_out !== 16'h0000 || mem_addr_out !== 16'h0000 || pc_out !== 16'h0000) begin
            errors++; $display("FAIL reset_vals ir=%h addr=%h pc=%h want 0000", ir_data_out, mem_addr_out, pc_out);
        end
        reset_in = 1'b0;
        tick();
        checks++;
        if (busy_out !== 1'b0 || pc_out !== 16'h0000 || mem_req_out !== 1'b0) begin
            errors++; $display("FAIL post_reset busy=%b pc=%h req=%b want 0 0000 0", busy_out, pc_out, mem_req_out);
        end
    endtask

    task automatic test_immediate_ack();
        fetch_start_in = 1'b1;
        tick();
        fetch_start_in = 1'b0;
        checks++;
        if (mem_req_out !== 1'b1 || mem_addr_out !== 16'h0000 || busy_out !== 1'b1) begin
            errors++; $display("FAIL imm_hi req=%b addr=%h busy=%b want 1 0000 1", mem_req_out, mem_addr_out, busy_out);
        end
        mem_ack_in = 1'b1; mem_data_in = 8'h12;
        tick();
        checks++;
        if (mem_req_out !== 1'b1 || mem_addr_out !== 16'h0001) begin
            errors++; $display("FAIL imm_lo req=%b addr=%h want 1 0001", mem_req_out, mem_addr_out);
        end
        mem_data_in = 8'h34;
        tick();
        mem_ack_in = 1'b0;
        checks++;
        if (ir_write_en_out !== 1'b1 || ir_data_out !== 16'h1234 || mem_req_out !== 1'b0) begin
            errors++; $display("FAIL imm_write we=%b data=%h req=%b want 1 1234 0", ir_write_en_out, ir_data_out, mem_req_out);
        end
        tick();
        checks++;
        if (pc_out !== 16'h0002 || ir_write_en_out !== 1'b0 || busy_out !== 1'b0 || ir_data_out !== 16'h1234) begin
            errors++; $display("FAIL imm_done pc=%h we=%b busy=%b data=%h want 0002 0 0 1234", pc_out, ir_write_en_out, busy_out, ir_data_out);
        end
    endtask

    task automatic test_wait_states();
        int strobes;
        logic stable;
        strobes = 0;
        stable = 1'b1;
        fetch_start_in = 1'b1;
        tick();
        // Start/jump requests during the busy window must be dropped.
        jump_en_in = 1'b1; jump_addr_in = 16'h5555;
        for (int i = 0; i < 4; i++) begin
            if (mem_req_out !== 1'b1 || mem_addr_out !== 16'h0002) stable = 1'b0;
            if (ir_write_en_out) strobes++;
            tick();
        end
        mem_ack_in = 1'b1; mem_data_in = 8'hAB;
        tick();
        mem_ack_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (mem_req_out !== 1'b1 || mem_addr_out !== 16'h0003) stable = 1'b0;
            if (ir_write_en_out) strobes++;
            tick();
        end
        fetch_start_in = 1'b0; jump_en_in = 1'b0;
        mem_ack_in = 1'b1; mem_data_in = 8'hCD;
        tick();
        mem_ack_in = 1'b0;
        checks++;
        if (stable !== 1'b1) begin
            errors++; $display("FAIL wait_stable got %b want 1", stable);
        end
        checks++;
        if (ir_write_en_out !== 1'b1 || ir_data_out !== 16'hABCD) begin
            errors++; $display("FAIL wait_write we=%b data=%h want 1 abcd", ir_write_en_out, ir_data_out);
        end
        tick();
        if (ir_write_en_out) strobes++;
        tick();
        if (ir_write_en_out) strobes++;
        checks++;
        if (strobes != 0 || pc_out !== 16'h0004 || busy_out !== 1'b0) begin
            errors++; $display("FAIL wait_done extra=%0d pc=%h busy=%b want 0 0004 0", strobes, pc_out, busy_out);
        end
    endtask

    task automatic test_jump_start();
        jump_en_in = 1'b1; jump_addr_in = 16'h0100; fetch_start_in = 1'b1;
        tick();
        jump_en_in = 1'b0; fetch_start_in = 1'b0;
        checks++;
        if (mem_addr_out !== 16'h0100 || mem_req_out !== 1'b1 || pc_out !== 16'h0100) begin
            errors++; $display("FAIL jump_hi addr=%h req=%b pc=%h want 0100 1 0100", mem_addr_out, mem_req_out, pc_out);
        end
        mem_ack_in = 1'b1; mem_data_in = 8'h56;
        tick();
        checks++;
        if (mem_addr_out !== 16'h0101) begin
            errors++; $display("FAIL jump_lo addr=%h want 0101", mem_addr_out);
        end
        mem_data_in = 8'h78;
        tick();
        mem_ack_in = 1'b0;
        checks++;
        if (ir_write_en_out !== 1'b1 || ir_data_out !== 16'h5678) begin
            errors++; $display("FAIL jump_write we=%b data=%h want 1 5678", ir_write_en_out, ir_data_out);
        end
        tick();
        checks++;
        if (pc_out !== 16'h0102) begin
            errors++; $display("FAIL jump_pc got %h want 0102", pc_out);
        end
    endtask

    task automatic test_wrap();
        jump_en_in = 1'b1; jump_addr_in = 16'hFFFE;
        tick();
        jump_en_in = 1'b0;
        checks++;
        if (pc_out !== 16'hFFFE || busy_out !== 1'b0) begin
            errors++; $display("FAIL jump_only pc=%h busy=%b want fffe 0", pc_out, busy_out);
        end
        fetch_start_in = 1'b1;
        tick();
        fetch_start_in = 1'b0;
        checks++;
        if (mem_addr_out !== 16'hFFFE) begin
            errors++; $display("FAIL wrap_hi addr=%h want fffe", mem_addr_out);
        end
        mem_ack_in = 1'b1; mem_data_in = 8'h11;
        tick();
        checks++;
        if (mem_addr_out !== 16'hFFFF) begin
            errors++; $display("FAIL wrap_lo addr=%h want ffff", mem_addr_out);
        end
        mem_data_in = 8'h22;
        tick();
        mem_ack_in = 1'b0;
        tick();
        checks++;
        if (pc_out !== 16'h0000 || ir_data_out !== 16'h1122) begin
            errors++; $display("FAIL wrap_pc pc=%h data=%h want 0000 1122", pc_out, ir_data_out);
        end
    endtask

    task automatic test_abort_lo();
        fetch_start_in = 1'b1;
        tick();
        fetch_start_in = 1'b0;
        mem_ack_in = 1'b1; mem_data_in = 8'h9A;
        tick();
        mem_ack_in = 1'b0; abort_in = 1'b1;
        tick();
        abort_in = 1'b0;
        checks++;
        if (busy_out !== 1'b0 || ir_write_en_out !== 1'b0 || mem_req_out !== 1'b0 || pc_out !== 16'h0000 || ir_data_out !== 16'h1122) begin
            errors++; $display("FAIL abort_lo busy=%b we=%b req=%b pc=%h data=%h want 0 0 0 0000 1122",
                               busy_out, ir_write_en_out, mem_req_out, pc_out, ir_data_out);
        end
        fetch_start_in = 1'b1;
        tick();
        fetch_start_in = 1'b0;
        checks++;
        if (mem_addr_out !== 16'h0000 || mem_req_out !== 1'b1) begin
            errors++; $display("FAIL refetch_hi addr=%h req=%b want 0000 1", mem_addr_out, mem_req_out);
        end
        mem_ack_in = 1'b1; mem_data_in = 8'hBC;
        tick();
        mem_data_in = 8'hDE;
        tick();
        mem_ack_in = 1'b0;
        checks++;
        if (ir_write_en_out !== 1'b1 || ir_data_out !== 16'hBCDE) begin
            errors++; $display("FAIL refetch_write we=%b data=%h want 1 bcde", ir_write_en_out, ir_data_out);
        end
        tick();
        checks++;
        if (pc_out !== 16'h0002) begin
            errors++; $display("FAIL refetch_pc got %h want 0002", pc_out);
        end
    endtask

    task automatic test_abort_write();
        fetch_start_in = 1'b1;
        tick();
        fetch_start_in = 1'b0;
        mem_ack_in = 1'b1; mem_data_in = 8'h0F;
        tick();
        mem_data_in = 8'hF0;
        tick();
        mem_ack_in = 1'b0; abort_in = 1'b1;
        checks++;
        if (ir_write_en_out !== 1'b1 || ir_data_out !== 16'h0FF0) begin
            errors++; $display("FAIL abort_wr_strobe we=%b data=%h want 1 0ff0", ir_write_en_out, ir_data_out);
        end
        tick();
        abort_in = 1'b0;
        checks++;
        if (pc_out !== 16'h0002 || busy_out !== 1'b0) begin
            errors++; $display("FAIL abort_wr_pc pc=%h busy=%b want 0002 0", pc_out, busy_out);
        end
    endtask

    task automatic test_reset_midfetch();
        int strobes;
        strobes = 0;
        fetch_start_in = 1'b1;
        tick();
        fetch_start_in = 1'b0;
        reset_in = 1'b1; mem_ack_in = 1'b1; mem_data_in = 8'h77;
        tick();
        reset_in = 1'b0;
        checks++;
        if (mem_req_out !== 1'b0 || pc_out !== 16'h0000 || busy_out !== 1'b0 || ir_data_out !== 16'h0000) begin
            errors++; $display("FAIL reset_mid req=%b pc=%h busy=%b data=%h want 0 0000 0 0000",
                               mem_req_out, pc_out, busy_out, ir_data_out);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (ir_write_en_out || busy_out) strobes++;
        end
        mem_ack_in = 1'b0;
        checks++;
        if (strobes != 0) begin
            errors++; $display("FAIL stray_ack activity=%0d want 0", strobes);
        end
    endtask

    initial begin
        test_reset();
        test_immediate_ack();
        test_wait_states();
        test_jump_start();
        test_wrap();
        test_abort_lo();
        test_abort_write();
        test_reset_midfetch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter PC_RESET, default 16'h0000: program counter value loaded by reset.
REQ-002 clk_in  input  1  single clock; all state updates on its rising edge.
REQ-003 reset_in  input  1  reset, synchronous, active-high.
REQ-004 fetch_start_in  input  1  request one instruction fetch; honoured only in IDLE.
REQ-005 jump_en_in  input  1  load PC from jump_addr_in; honoured only in IDLE.
REQ-006 jump_addr_in  input  16  byte address of the jump target.
REQ-007 abort_in  input  1  cancel the fetch in progress.
REQ-008 mem_req_out  output  1  memory byte-read request.
REQ-009 mem_addr_out  output  16  byte address of the current request.
REQ-010 mem_ack_in  input  1  memory has valid data on mem_data_in this cycle.
REQ-011 mem_data_in  input  8  memory read data.
REQ-012 ir_write_en_out  output  1  one-cycle write strobe to the instruction register.
REQ-013 ir_data_out  output  16  assembled instruction word.
REQ-014 pc_out  output  16  current program counter (byte address).
REQ-015 busy_out  output  1  high in every state except IDLE.

Function
REQ-016 The FSM SHALL have four states: IDLE, REQ_HI, REQ_LO, WRITE.
REQ-017 In IDLE with jump_en_in=1, PC SHALL load jump_addr_in on the next edge.
REQ-018 In IDLE with fetch_start_in=1, the FSM SHALL enter REQ_HI on the next edge.
REQ-019 If both arrive together, the jump SHALL take effect and the fetch SHALL start at jump_addr_in.
REQ-020 mem_req_out SHALL be 1 exactly in REQ_HI and REQ_LO.
REQ-021 mem_addr_out SHALL equal PC in REQ_HI, PC+1 (mod 2^16) in REQ_LO, and PC otherwise.
REQ-022 In REQ_HI, mem_ack_in=1 SHALL capture mem_data_in as instruction bits [15:8] and move to REQ_LO.
REQ-023 In REQ_LO, mem_ack_in=1 SHALL capture mem_data_in as bits [7:0] and move to WRITE.
REQ-024 Absent mem_ack_in, REQ_HI/REQ_LO SHALL hold state, request and address unchanged (unbounded wait).
REQ-025 mem_ack_in outside REQ_HI/REQ_LO SHALL be ignored.
REQ-026 WRITE SHALL last exactly one cycle: ir_write_en_out=1, ir_data_out={hi,lo}, then IDLE.
REQ-027 On leaving WRITE, PC SHALL become PC+2 mod 2^16 (16'hFFFE wraps to 16'h0000).
REQ-028 ir_data_out SHALL hold its last assembled value outside WRITE.
REQ-029 Minimum latency, fetch_start_in to ir_write_en_out with ack in the first cycle of each request, SHALL be 3 cycles.
REQ-030 abort_in=1 in REQ_HI, REQ_LO or WRITE SHALL force IDLE on the next edge, with PC unchanged.
REQ-031 An abort asserted in WRITE SHALL NOT suppress that cycle's strobe, but the PC increment SHALL be cancelled.
REQ-032 Partial captured bytes SHALL be discarded on abort.
REQ-033 fetch_start_in and jump_en_in while busy_out=1 SHALL be ignored, not queued.

Reset
REQ-034 reset_in SHALL force IDLE and PC=PC_RESET, with priority over all other inputs, including mid-fetch.
REQ-035 During and after reset: mem_req_out=0, ir_write_en_out=0, busy_out=0, ir_data_out=16'h0000, mem_addr_out=PC_RESET.

Verification
REQ-036 Immediate ack: reset, PC=0, memory[0]=8'h12, [1]=8'h34, fetch_start_in -> addresses 0 then 1, ir_write_en_out on cycle 3 with ir_data_out=16'h1234, pc_out=2.
REQ-037 Wait states: ack delayed 4 cycles per byte -> mem_req_out and mem_addr_out stable throughout, single strobe, data correct.
REQ-038 Jump with simultaneous start: jump_addr_in=16'h0100 and fetch_start_in together -> requests at 16'h0100/16'h0101, pc_out=16'h0102 afterwards.
REQ-039 Wrap: PC=16'hFFFE, fetch -> requests at 16'hFFFE/16'hFFFF, pc_out=16'h0000 afterwards.
REQ-040 Abort in REQ_LO after high-byte ack -> IDLE next cycle, no strobe, pc_out unchanged; the next fetch re-reads both bytes.
REQ-041 Reset during REQ_HI with ack pending -> mem_req_out=0 next cycle, pc_out=PC_RESET; stray ack afterwards causes no strobe.
